// File: rtl/serial_word_rx_pkg.sv
// Shared definitions for the serial word receiver: default sizing and FSM encodings.
package serial_word_rx_pkg;

    localparam int unsigned DefaultN  = 8;
    localparam int unsigned DefaultCW = 4;

    typedef enum logic {
        RxIdle = 1'b0,
        RxRecv = 1'b1
    } rx_state_e;

    typedef enum logic {
        OutEmpty = 1'b0,
        OutFull  = 1'b1
    } out_state_e;

endpackage

// File: rtl/sipo_shiftreg.sv
// Left-shift serial-in parallel-out register; inverse of the parallel-load MSB-first shifter.
module sipo_shiftreg #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         Din,
    output logic [N-1:0] q
);

    logic [N-1:0] sr_q;
    logic [N-1:0] sr_d;

    // A clear coinciding with a valid bit restarts the word with that bit.
    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = en ? {{(N-1){1'b0}}, Din} : '0;
        end else if (en) begin
            sr_d = {sr_q[N-2:0], Din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q;

endmodule

// File: rtl/serial_word_rx.sv
// Serial-in word receiver with double-buffered valid/ready output and sticky overrun flag.
module serial_word_rx
    import serial_word_rx_pkg::*;
#(
    parameter int unsigned N  = DefaultN,
    parameter int unsigned CW = DefaultCW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          Din,
    input  logic          Din_valid,
    input  logic          out_ready,
    input  logic          clr_ovr,
    output logic [N-1:0]  Dout,
    output logic          out_valid,
    output logic          overrun,
    output logic          busy,
    output logic [CW-1:0] bit_cnt
);

    rx_state_e  rx_state_q, rx_state_d;
    out_state_e out_state_q, out_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          ovr_q, ovr_d;
    logic [N-1:0]  shreg;
    logic [N-1:0]  word;
    logic          complete;
    logic          ovr_set;

    sipo_shiftreg #(
        .N(N)
    ) u_shreg (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start),
        .en   (Din_valid),
        .Din  (Din),
        .q    (shreg)
    );

    // A bit arriving with start opens a new word, so it can never complete one.
    assign complete = Din_valid && !start && (cnt_q == CW'(N - 1));
    assign word     = {shreg[N-2:0], Din};

    always_comb begin
        cnt_d      = cnt_q;
        rx_state_d = rx_state_q;
        if (start) begin
            cnt_d      = Din_valid ? CW'(1) : '0;
            rx_state_d = Din_valid ? RxRecv : RxIdle;
        end else if (Din_valid) begin
            if (complete) begin
                cnt_d      = '0;
                rx_state_d = RxIdle;
            end else begin
                cnt_d      = cnt_q + CW'(1);
                rx_state_d = RxRecv;
            end
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        dout_d      = dout_q;
        ovr_set     = 1'b0;
        unique case (out_state_q)
            OutEmpty: begin
                if (complete) begin
                    dout_d      = word;
                    out_state_d = OutFull;
                end
            end
            OutFull: begin
                if (out_ready) begin
                    if (complete) begin
                        dout_d = word;
                    end else begin
                        out_state_d = OutEmpty;
                    end
                end else if (complete) begin
                    ovr_set = 1'b1;
                end
            end
            default: out_state_d = OutEmpty;
        endcase
        ovr_d = ovr_set ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q  <= RxIdle;
            out_state_q <= OutEmpty;
            cnt_q       <= '0;
            dout_q      <= '0;
            ovr_q       <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            out_state_q <= out_state_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            ovr_q       <= ovr_d;
        end
    end

    assign Dout      = dout_q;
    assign out_valid = (out_state_q == OutFull);
    assign overrun   = ovr_q;
    assign busy      = (rx_state_q == RxRecv);
    assign bit_cnt   = cnt_q;

endmodule
